fifo_wr_ctrl: RTL

- Write-side controller for the asynchronous FIFO. It sequences writes into fifo_mem: it owns the write pointer, drives the memory write address, and generates the full flag that gates fifo_mem's write enable.
- It brings the read-domain Gray pointer in through a synchronizer and exports its own Gray write pointer to the read domain.
- It also reports fill level, almost-full, and overflow attempts.
- Sits entirely in the write clock domain, between the producer and fifo_mem / the read-side controller.

---
 rtl/fifo_wr_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for an async FIFO: owns the write pointer, syncs the read pointer, raises full/almost-full/level/overflow.
// Latency: the address and flags update on the accepting edge; a read-pointer change reaches the flags after SYNC_STAGES+1 edges.
// Backpressure: while w_full_out is high, requests are refused and the pointer holds; each refused request gives a one-cycle w_overflow_out.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                  w_clk_in,
    input  logic                  w_rst_n_in,
    input  logic                  w_request_in,
    input  logic [ADDR_WIDTH:0]   r_gray_ptr_in,
    output logic [ADDR_WIDTH-1:0] w_addr_out,
    output logic [ADDR_WIDTH:0]   w_gray_ptr_out,
    output logic                  w_full_out,
    output logic                  w_almost_full_out,
    output logic [ADDR_WIDTH:0]   w_level_out,
    output logic                  w_overflow_out
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AFULL_THR = PW'(DEPTH - AFULL_MARGIN);
    // The read pointer one full lap behind differs in exactly the two Gray MSBs.
    localparam logic [PW-1:0] FULL_MASK = PW'(3 << (ADDR_WIDTH - 1));

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] rq_sync;
    logic [PW-1:0] rbin_sync;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          accept;

    // Plain flop chain: nothing may be inserted between stages.
    always_ff @(posedge w_clk_in or negedge w_rst_n_in) begin
        if (!w_rst_n_in) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= r_gray_ptr_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rq_sync   = sync_q[SYNC_STAGES-1];
    assign rbin_sync = gray2bin(rq_sync);

    assign accept  = w_request_in & ~full_q;
    assign wbin_d  = wbin_q + PW'(accept);
    assign wgray_d = wbin_d ^ (wbin_d >> 1);
    assign level_d = wbin_d - rbin_sync;
    assign full_d  = (wgray_d == (rq_sync ^ FULL_MASK));
    assign afull_d = (level_d >= AFULL_THR);
    assign ovf_d   = w_request_in & full_q;

    always_ff @(posedge w_clk_in or negedge w_rst_n_in) begin
        if (!w_rst_n_in) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign w_addr_out        = wbin_q[ADDR_WIDTH-1:0];
    assign w_gray_ptr_out    = wgray_q;
    assign w_full_out        = full_q;
    assign w_almost_full_out = afull_q;
    assign w_level_out       = level_q;
    assign w_overflow_out    = ovf_q;

endmodule
